// File: rtl/pos_walker_pkg.sv
// Shared definitions for the position walker.
// Holds the command-word field positions, the axis/sign codes, and the
// stepping function. The function is written once for any coordinate
// width up to CALC_W-1 bits and any overflow mode.
package pos_walk_pkg;

   localparam bit AXIS_X   = 1'b0;
   localparam bit AXIS_Y   = 1'b1;
   localparam bit SIGN_ADD = 1'b0;
   localparam bit SIGN_SUB = 1'b1;

   // Internal arithmetic width. Coordinates are zero-extended into it.
   localparam int CALC_W = 32;
   localparam int XW     = CALC_W + 2;

   // Bit positions inside the command word: {axis, sign, magnitude}.
   function automatic int cmd_w(input int step_w);
      return step_w + 2;
   endfunction

   function automatic int cmd_axis_bit(input int step_w);
      return step_w + 1;
   endfunction

   function automatic int cmd_sign_bit(input int step_w);
      return step_w;
   endfunction

   typedef struct packed {
      logic              clip;
      logic [CALC_W-1:0] val;
   } step_res_t;

   // Applies cur +/- mag for a w-bit coordinate.
   // wrap=1 keeps the low w bits and never reports a clip.
   // wrap=0 clamps to [0, 2^w-1] and reports a clip when the clamp fired.
   function automatic step_res_t step_calc(input int w, input bit wrap,
                                           input logic [CALC_W-1:0] cur,
                                           input logic [CALC_W-1:0] mag,
                                           input logic sub);
      logic signed [XW-1:0] t;
      logic signed [XW-1:0] max_v;
      step_res_t r;
      max_v = (XW'(1) << w) - XW'(1);
      if (sub == SIGN_SUB) t = $signed({2'b00, cur}) - $signed({2'b00, mag});
      else                 t = $signed({2'b00, cur}) + $signed({2'b00, mag});
      r.clip = 1'b0;
      r.val  = t[CALC_W-1:0];
      if (wrap) begin
         r.val = t[CALC_W-1:0] & max_v[CALC_W-1:0];
      end else if (t < 0) begin
         r.val  = '0;
         r.clip = 1'b1;
      end else if (t > max_v) begin
         r.val  = max_v[CALC_W-1:0];
         r.clip = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pos_walker_if.sv
// Bundle between the switch/encoder front end and the walker.
// Inputs to the walker: rot_a, rot_b (synchronised encoder lines), cmd
// ({axis, sign, magnitude}), undo (level).
// Outputs from the walker: x, y, moved, clipped, hist_cnt, hist_full.
// Event protocol (there is no valid/ready): a step fires on the first
// cycle both encoder lines are sampled high after having been sampled both
// low; cmd must be stable in the cycle after that sample. An undo fires
// on a sampled rising edge of undo. Results appear one edge later.
interface pos_walker_if #(
   parameter int W      = 4,
   parameter int STEP_W = 2,
   parameter int DEPTH  = 4
);
   logic                         rot_a;
   logic                         rot_b;
   logic [STEP_W+1:0]            cmd;
   logic                         undo;
   logic [W-1:0]                 x;
   logic [W-1:0]                 y;
   logic                         moved;
   logic                         clipped;
   logic [$clog2(DEPTH+1)-1:0]   hist_cnt;
   logic                         hist_full;

   modport master (
      output rot_a, rot_b, cmd, undo,
      input  x, y, moved, clipped, hist_cnt, hist_full
   );

   modport slave (
      input  rot_a, rot_b, cmd, undo,
      output x, y, moved, clipped, hist_cnt, hist_full
   );
endinterface

// File: rtl/pos_walker_lifo.sv
// Bounded LIFO of past (x,y) positions.
// Ports: clk, reset (sync, active-high), push_i/din_i store an entry,
// pop_i removes the newest, dout_o is the newest entry, cnt_o the number
// of valid entries, full_o/empty_o the count limits.
// Entry 0 is the newest; a push shifts everything one slot older, so the
// oldest entry falls off the end when the store is already full.
module pos_hist_lifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH+1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [DW-1:0]    din_i,
   output logic [DW-1:0]    dout_o,
   output logic [CNT_W-1:0] cnt_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [DW-1:0]    mem_q [DEPTH];
   logic [CNT_W-1:0] cnt_q;

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[0];
   assign cnt_o   = cnt_q;

   // Storage needs no reset: cnt_q alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (push_i) begin
         for (int i = DEPTH - 1; i > 0; i--) mem_q[i] <= mem_q[i-1];
         mem_q[0] <= din_i;
      end else if (pop_i && !empty_o) begin
         for (int i = 0; i < DEPTH - 1; i++) mem_q[i] <= mem_q[i+1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (push_i) begin
         if (!full_o) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop_i && !empty_o) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end
endmodule

// File: rtl/pos_walker.sv
// 2-D position walker driven by a quadrature rotary encoder.
// Ports: clk, reset (sync, active-high) and a pos_walker_if slave bundle
// carrying the encoder lines, command word, undo level, the registered x/y
// coordinates, moved/clipped pulses and the undo-history count/full flag.
// This level only detects events, does the step arithmetic and arbitrates
// between step and undo; history storage lives in pos_hist_lifo.
module pos_walker
   import pos_walk_pkg::*;
#(
   parameter int W      = 4,
   parameter int STEP_W = 2,
   parameter int DEPTH  = 4,
   parameter bit WRAP   = 1'b0
) (
   input logic         clk,
   input logic         reset,
   pos_walker_if.slave bus
);
   localparam int AXIS_BIT = cmd_axis_bit(STEP_W);
   localparam int SIGN_BIT = cmd_sign_bit(STEP_W);
   localparam int CNT_W    = $clog2(DEPTH+1);

   logic         rot_eve_q, prev_eve_q;
   logic         undo_s_q, undo_prev_q;
   logic [W-1:0] x_q, y_q;
   logic         moved_q, clipped_q;

   logic           step_ev, undo_req;
   logic           axis, sub;
   logic [STEP_W-1:0] mag;
   logic [W-1:0]   cur, nv;
   step_res_t      res;
   logic           changed, do_push, do_pop;
   logic [2*W-1:0] pop_data;
   logic           hist_empty;
   logic           unused_hi;

   assign step_ev  = rot_eve_q & ~prev_eve_q;
   assign undo_req = undo_s_q & ~undo_prev_q;

   assign axis = bus.cmd[AXIS_BIT];
   assign sub  = bus.cmd[SIGN_BIT];
   assign mag  = bus.cmd[STEP_W-1:0];
   assign cur  = (axis == AXIS_Y) ? y_q : x_q;

   always_comb begin
      res = step_calc(W, WRAP, CALC_W'(cur), CALC_W'(mag), sub);
   end

   assign nv        = res.val[W-1:0];
   assign unused_hi = ^res.val[CALC_W-1:W];
   assign changed   = (nv != cur);

   // Undo wins a same-cycle collision, so a step is only pushed alone.
   assign do_push = step_ev & ~undo_req & changed;
   assign do_pop  = undo_req & ~hist_empty;

   pos_hist_lifo #(.DW(2*W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_hist (
      .clk     (clk),
      .reset   (reset),
      .push_i  (do_push),
      .pop_i   (do_pop),
      .din_i   ({x_q, y_q}),
      .dout_o  (pop_data),
      .cnt_o   (bus.hist_cnt),
      .full_o  (bus.hist_full),
      .empty_o (hist_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         // Detent and undo trackers come up "already high" so an encoder
         // detent or undo held across reset is not counted.
         rot_eve_q   <= 1'b1;
         prev_eve_q  <= 1'b1;
         undo_s_q    <= 1'b1;
         undo_prev_q <= 1'b1;
         x_q         <= '0;
         y_q         <= '0;
         moved_q     <= 1'b0;
         clipped_q   <= 1'b0;
      end else begin
         if (bus.rot_a && bus.rot_b)        rot_eve_q <= 1'b1;
         else if (!bus.rot_a && !bus.rot_b) rot_eve_q <= 1'b0;
         prev_eve_q  <= rot_eve_q;
         undo_s_q    <= bus.undo;
         undo_prev_q <= undo_s_q;
         moved_q     <= 1'b0;
         clipped_q   <= 1'b0;
         if (undo_req) begin
            if (!hist_empty) begin
               x_q <= pop_data[2*W-1:W];
               y_q <= pop_data[W-1:0];
            end
         end else if (step_ev) begin
            clipped_q <= res.clip;
            if (changed) begin
               moved_q <= 1'b1;
               if (axis == AXIS_Y) y_q <= nv;
               else                x_q <= nv;
            end
         end
      end
   end

   assign bus.x       = x_q;
   assign bus.y       = y_q;
   assign bus.moved   = moved_q;
   assign bus.clipped = clipped_q;
endmodule
